uart_cmd_controller: RTL and testbench

UART_CMD_CONTROLLER -- requirements
Module: uart_cmd_controller

---
 rtl/uart_cmd_pkg.sv | 17 +
 rtl/uart_cmd_buf.sv | 25 ++
 rtl/uart_cmd_controller.sv | 183 ++++++++++++++++++
 tb/tb_uart_cmd_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state type and constants for the UART command controller
package uart_cmd_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_ISSUE
  } state_e;

endpackage

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - payload buffer, synchronous write and asynchronous read
module uart_cmd_buf
  import uart_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // No reset: contents are only read after being written by the current frame.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_cmd_controller.sv
// rtl/uart_cmd_controller.sv - UART frame parser issuing buffered register writes
// Optional checksum byte and compare enabled by UART_CMD_CHECKSUM_EN.
module uart_cmd_controller
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stb,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic              i_wr_ready,
  output logic              o_busy,
  output logic              o_frame_ok,
  output logic              o_frame_err,
  output logic              o_overrun
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        idx_q;
  logic [CW-1:0]     cnt_q;
  logic              wr_valid_q;
  logic              frame_ok_q;
  logic              frame_err_q;
  logic              overrun_q;
`ifdef UART_CMD_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  logic              parsing;
  logic              timeout;
  logic [DATA_W-1:0] rd_data;

  assign parsing = (state_q != S_IDLE) && (state_q != S_ISSUE);
  assign timeout = parsing && !i_stb && (cnt_q == TMO_LAST);

  uart_cmd_buf #(
    .DEPTH (MAX_LEN),
    .IW    (IW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    ((state_q == S_DATA) && i_stb),
    .i_waddr (idx_q[IW-1:0]),
    .i_wdata (i_data),
    .i_raddr (idx_q[IW-1:0]),
    .o_rdata (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      wr_valid_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      if (parsing && !i_stb) cnt_q <= cnt_q + 1'b1;
      else                   cnt_q <= '0;

      if (timeout) begin
        frame_err_q <= 1'b1;
        state_q     <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_stb && (i_data == SYNC_BYTE)) begin
              state_q <= S_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
              csum_q  <= '0;
`endif
            end
          end
          S_ADDR: begin
            if (i_stb) begin
              base_q  <= i_data;
              state_q <= S_LEN;
`ifdef UART_CMD_CHECKSUM_EN
              csum_q  <= csum_q ^ i_data;
`endif
            end
          end
          S_LEN: begin
            if (i_stb) begin
              if ((i_data == 8'd0) || (i_data > MAX_LEN_B)) begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
              end else begin
                len_q   <= i_data;
                idx_q   <= '0;
                state_q <= S_DATA;
              end
`ifdef UART_CMD_CHECKSUM_EN
              csum_q <= csum_q ^ i_data;
`endif
            end
          end
          S_DATA: begin
            if (i_stb) begin
`ifdef UART_CMD_CHECKSUM_EN
              csum_q <= csum_q ^ i_data;
`endif
              if (idx_q == len_q - 8'd1) begin
`ifdef UART_CMD_CHECKSUM_EN
                state_q    <= S_CSUM;
`else
                state_q    <= S_ISSUE;
                idx_q      <= '0;
                addr_q     <= base_q;
                wr_valid_q <= 1'b1;
`endif
              end else begin
                idx_q <= idx_q + 8'd1;
              end
            end
          end
`ifdef UART_CMD_CHECKSUM_EN
          S_CSUM: begin
            if (i_stb) begin
              if (i_data == csum_q) begin
                state_q    <= S_ISSUE;
                idx_q      <= '0;
                addr_q     <= base_q;
                wr_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
              end
            end
          end
`endif
          S_ISSUE: begin
            // Bytes arriving while writes drain are discarded, never parsed.
            if (i_stb) overrun_q <= 1'b1;
            if (i_wr_ready) begin
              if (idx_q == len_q - 8'd1) begin
                wr_valid_q <= 1'b0;
                frame_ok_q <= 1'b1;
                state_q    <= S_IDLE;
              end else begin
                idx_q  <= idx_q + 8'd1;
                addr_q <= addr_q + 8'd1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_wr_valid  = wr_valid_q;
  assign o_wr_addr   = addr_q;
  assign o_wr_data   = wr_valid_q ? rd_data : '0;
  assign o_busy      = (state_q != S_IDLE);
  assign o_frame_ok  = frame_ok_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// tb/tb_uart_cmd_controller.sv - self-checking bench for uart_cmd_controller
module tb_uart_cmd_controller;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic [7:0] din = 8'h00;
  logic       fix_rdy = 1'b1;
  logic       rnd_rdy = 1'b1;
  logic       rand_mode = 1'b0;
  wire        rdy = rand_mode ? rnd_rdy : fix_rdy;

  logic       wr_valid, busy, frame_ok, frame_err, overrun;
  logic [7:0] wr_addr, wr_data;

  int total = 0;
  int bad = 0;
  int ok_cnt = 0, err_cnt = 0, ovr_cnt = 0;
  int exp_ok = 0, exp_err = 0, exp_ovr = 0;
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  logic [7:0]  pay [256];

  logic       p_valid = 1'b0, p_rdy = 1'b0, p_rst = 1'b0;
  logic [7:0] p_addr = 8'h00, p_data = 8'h00;

  uart_cmd_controller #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_stb       (stb),
    .i_data      (din),
    .o_wr_valid  (wr_valid),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .i_wr_ready  (rdy),
    .o_busy      (busy),
    .o_frame_ok  (frame_ok),
    .o_frame_err (frame_err),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Observe accepted writes, pulses, and hold-stability under backpressure.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid && rdy) got_q.push_back({wr_addr, wr_data});
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
      if (overrun)   ovr_cnt++;
      if (p_rst && p_valid && !p_rdy) begin
        check("hold_valid", wr_valid, 1);
        check("hold_addr", wr_addr, p_addr);
        check("hold_data", wr_data, p_data);
      end
    end
    p_rst = rst_n; p_valid = wr_valid; p_rdy = rdy; p_addr = wr_addr; p_data = wr_data;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1; stb = 1'b1; din = b;
    @(posedge clk); #1; stb = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input int n, input bit bad_cs, input bit model);
    logic [7:0] cs;
    bit good;
    cs = a ^ 8'(n);
    good = (n >= 1) && (n <= MAX_LEN);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(8'(n));
    if (good) begin
      for (int i = 0; i < n; i++) begin
        cs ^= pay[i];
        send_byte(pay[i]);
      end
`ifdef UART_CMD_CHECKSUM_EN
      send_byte(bad_cs ? 8'h00 : cs);
      if (bad_cs && (cs != 8'h00)) good = 0;
`endif
    end
    if (model) begin
      if (good) begin
        for (int i = 0; i < n; i++) exp_q.push_back({a + 8'(i), pay[i]});
        exp_ok++;
      end else begin
        exp_err++;
      end
      check("first_valid", wr_valid, good);
    end
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
    check({tag, "_ok"}, ok_cnt, exp_ok);
    check({tag, "_err"}, err_cnt, exp_err);
    check({tag, "_ovr"}, ovr_cnt, exp_ovr);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int first;
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {frame_ok, frame_err, overrun}, 0);

    send_byte(8'h3C);
    send_byte(8'h00);
    check("junk_busy", busy, 0);

    pay[0] = 8'h11; pay[1] = 8'h22;
    send_frame(8'h10, 2, 0, 1);
    wait_idle(100);
    check_all("basic");

`ifdef UART_CMD_CHECKSUM_EN
    send_frame(8'h10, 2, 1, 1);
    wait_idle(100);
    check_all("badcsum");
`endif

    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    send_frame(8'hFF, 3, 0, 1);
    wait_idle(100);
    check_all("wrap");

    fix_rdy = 1'b0;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    send_frame(8'h40, 3, 0, 1);
    send_byte(8'hA5);
    exp_ovr++;
    repeat (3) @(posedge clk);
    #1 fix_rdy = 1'b1;
    wait_idle(100);
    check_all("bp");

    send_byte(8'hA5);
    send_byte(8'h10);
    first = 0;
    for (int k = 1; k <= TMO + 8; k++) begin
      @(negedge clk);
      if (frame_err && first == 0) first = k;
    end
    exp_err++;
    check("tmo_window", (first >= TMO) && (first <= TMO + 2), 1);
    check("tmo_idle", busy, 0);
    pay[0] = 8'h5E;
    send_frame(8'h77, 1, 0, 1);
    wait_idle(100);
    check_all("tmo");

    send_frame(8'h30, 0, 0, 1);
    wait_idle(10);
    send_frame(8'h30, MAX_LEN + 1, 0, 1);
    wait_idle(10);
    check_all("badlen");

    rand_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      n = (f == 0) ? MAX_LEN : int'($urandom_range(1, MAX_LEN));
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      send_frame(8'($urandom), n, 0, 1);
      wait_idle(400);
    end
    rand_mode = 1'b0;
    check_all("rand");

    fix_rdy = 1'b0;
    for (int i = 0; i < 4; i++) pay[i] = 8'(i + 8'h90);
    send_frame(8'h20, 4, 0, 0);
    check("pre_rst_valid", wr_valid, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("mid_rst_valid", wr_valid, 0);
    check("mid_rst_addr", wr_addr, 0);
    check("mid_rst_data", wr_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pulses", {frame_ok, frame_err, overrun}, 0);
    fix_rdy = 1'b1;
    repeat (30) @(negedge clk);
    check_all("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
